// File: rtl/fpu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_sched
// Purpose  : Issue scheduler between the core FP request port and the FPU
//            wrapper. Allows back-to-back issue by tracking, per future edge,
//            whether a result is due (resv) and which tag it belongs to
//            (tag_slot). A request is only accepted if its writeback edge is
//            free, so no two results ever complete on the same edge.
// Ports    : clk, rstn              clock / async active-low reset
//            req_valid/ready        core request handshake (ready is comb.)
//            req_ctl/x1/x2/tag      opcode, operands, destination tag
//            fpu_en/ctl/x1/x2       issue strobe and held operands to FPU
//            fpu_y/fpu_ready        FPU result and its valid
//            res_valid/data/tag     one-cycle tagged result to core
//            busy                   anything issued or in flight
//            err_illegal            sticky: unsupported opcode accepted
//            err_protocol           sticky: fpu_ready disagreed with schedule
// Revision : 1.0  initial release
// ============================================================================
module fpu_issue_sched #(
  parameter int TAG_W    = 4,
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_INV  = 4,
  parameter int LAT_DIV  = 6,
  parameter int LAT_MISC = 1,
  parameter int MAX_LAT  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_ctl,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fpu_en,
  output logic [3:0]       fpu_ctl,
  output logic [31:0]      fpu_x1,
  output logic [31:0]      fpu_x2,
  input  logic [31:0]      fpu_y,
  input  logic             fpu_ready,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_protocol
);

  localparam int RW = MAX_LAT + 2;          // reservation vector is [RW:1]
  localparam int LW = $clog2(RW + 1);       // wide enough to index slot RW

  localparam logic [3:0] OP_FADD  = 4'd2;
  localparam logic [3:0] OP_FSUB  = 4'd3;
  localparam logic [3:0] OP_FMUL  = 4'd4;
  localparam logic [3:0] OP_FINV  = 4'd5;
  localparam logic [3:0] OP_FDIV  = 4'd6;
  localparam logic [3:0] OP_FHALF = 4'd7;
  localparam logic [3:0] OP_FEQ   = 4'd11;
  localparam logic [3:0] OP_FLE   = 4'd12;
  localparam logic [3:0] OP_FABS  = 4'd13;
  localparam logic [3:0] OP_FNEG  = 4'd14;

  logic [LW-1:0]    lat;
  logic             legal;
  logic [LW-1:0]    chk_idx;
  logic [LW-1:0]    slot_idx;
  logic             accept;
  logic             issue;
  logic [RW:1]      resv;
  logic [RW:1]      resv_nxt;
  logic [TAG_W-1:0] tag_slot [1:RW];
  logic [TAG_W-1:0] tag_nxt  [1:RW];

  // Latency lookup for the opcode currently presented by the core.
  always_comb begin
    legal = 1'b1;
    lat   = '0;
    case (req_ctl)
      OP_FADD, OP_FSUB:                       lat = LW'(LAT_ADD);
      OP_FMUL:                                lat = LW'(LAT_MUL);
      OP_FINV:                                lat = LW'(LAT_INV);
      OP_FDIV:                                lat = LW'(LAT_DIV);
      OP_FHALF, OP_FEQ, OP_FLE, OP_FABS,
      OP_FNEG:                                lat = LW'(LAT_MISC);
      default:                                legal = 1'b0;
    endcase
  end

  // The new reservation lands in slot L+1 after this edge's shift, i.e. it
  // collides with whatever currently sits in slot L+2.
  assign chk_idx  = lat + LW'(2);
  assign slot_idx = lat + LW'(1);

  // Illegal opcodes are always accepted so they get flagged rather than stall.
  assign req_ready = legal ? ~resv[chk_idx] : 1'b1;
  assign accept    = req_valid & req_ready;
  assign issue     = accept & legal;

  assign busy = fpu_en | (|resv);

  // Shift the schedule by one edge and insert the new reservation. L >= 1, so
  // the insertion never touches slot 1 and cannot clash with writeback.
  always_comb begin
    resv_nxt = {1'b0, resv[RW:2]};
    for (int i = 1; i < RW; i++) begin
      tag_nxt[i] = tag_slot[i+1];
    end
    tag_nxt[RW] = '0;
    if (issue) begin
      resv_nxt[slot_idx] = 1'b1;
      tag_nxt[slot_idx]  = req_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpu_en       <= 1'b0;
      fpu_ctl      <= '0;
      fpu_x1       <= '0;
      fpu_x2       <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_tag      <= '0;
      err_illegal  <= 1'b0;
      err_protocol <= 1'b0;
      resv         <= '0;
      tag_slot     <= '{default: '0};
    end else begin
      fpu_en <= issue;
      if (issue) begin
        fpu_ctl <= req_ctl;
        fpu_x1  <= req_x1;
        fpu_x2  <= req_x2;
      end
      if (accept && !legal) begin
        err_illegal <= 1'b1;
      end

      // Writeback is driven by the schedule, not by fpu_ready: a scheduled
      // result is always returned (with whatever fpu_y holds) so the core
      // never waits forever on a tag; a mismatch is only flagged.
      res_valid <= resv[1];
      if (resv[1]) begin
        res_data <= fpu_y;
        res_tag  <= tag_slot[1];
      end
      if (resv[1] != fpu_ready) begin
        err_protocol <= 1'b1;
      end

      resv     <= resv_nxt;
      tag_slot <= tag_nxt;
    end
  end

endmodule
`default_nettype wire
